// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage driving a 2-cycle-latency IM read port
//            and buffering returned words in a queue for decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_mem_ready,
  output logic        o_im_ren,
  output logic [13:0] o_im_addr,
  input  logic [31:0] i_im_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW+1:0] C_QDEPTH_W = (AW+2)'(QDEPTH);

  logic [31:0] fpc_q, fpc_d;
  logic        s0_v_q, s1_v_q;
  logic [31:0] s0_pc_q, s1_pc_q;
  logic [31:0] q_inst_q [QDEPTH];
  logic [31:0] q_pc_q   [QDEPTH];
  logic [AW:0] wptr_q, rptr_q, count_q, count_d;

  logic [AW+1:0] outstanding;
  logic          issue, enq, deq;

  // Credit covers everything already issued, so a returning word always has a slot.
  assign outstanding = {1'b0, count_q} + (AW+2)'(s0_v_q) + (AW+2)'(s1_v_q);
  assign issue       = !i_rst && !i_redirect && i_mem_ready && (outstanding < C_QDEPTH_W);
  assign enq         = s1_v_q && !i_redirect && !i_rst;
  assign deq         = (count_q != '0) && i_inst_ready && !i_redirect && !i_rst;

  always_comb begin
    fpc_d   = fpc_q;
    count_d = count_q;
    if (issue) fpc_d = fpc_q + 32'd4;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fpc_q   <= {RESET_PC[31:2], 2'b00};
      s0_v_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      s0_pc_q <= '0;
      s1_pc_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (i_redirect) begin
      fpc_q   <= {i_redirect_pc[31:2], 2'b00};
      s0_v_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      fpc_q   <= fpc_d;
      s0_v_q  <= issue;
      s0_pc_q <= fpc_q;
      s1_v_q  <= s0_v_q;
      s1_pc_q <= s0_pc_q;
      if (enq) wptr_q <= wptr_q + 1'b1;
      if (deq) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      q_inst_q[wptr_q[AW-1:0]] <= i_im_rdata;
      q_pc_q[wptr_q[AW-1:0]]   <= s1_pc_q;
    end
  end

  assign o_im_ren     = issue;
  assign o_im_addr    = fpc_q[15:2];
  assign o_inst_valid = (count_q != '0);
  assign o_inst       = o_inst_valid ? q_inst_q[rptr_q[AW-1:0]] : 32'h0;
  assign o_inst_pc    = o_inst_valid ? q_pc_q[rptr_q[AW-1:0]]   : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a transaction-level
//            model of issued-but-unconsumed fetches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          QDEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_ready = 1'b1;
  logic        im_ren;
  logic [13:0] im_addr;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_mem_ready  (mem_ready),
    .o_im_ren     (im_ren),
    .o_im_addr    (im_addr),
    .i_im_rdata   (im_rdata),
    .o_inst_valid (inst_valid),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .i_inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  // Memory: word[i] = i, returned exactly two cycles after the read; junk otherwise.
  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [13:0] p0_a = '0, p1_a = '0;
  logic [31:0] junk = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    p0_v <= im_ren;
    p0_a <= im_addr;
    p1_v <= p0_v;
    p1_a <= p0_a;
    junk <= $urandom;
  end
  assign im_rdata = p1_v ? {18'h0, p1_a} : junk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Model: issue cycle of every fetch not yet consumed, plus next fetch / head PCs.
  int          outst[$];
  logic [31:0] m_fpc  = RESET_PC;
  logic [31:0] m_head = RESET_PC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic exp_ren, exp_valid;
    @(negedge clk);
    exp_ren   = !rst && !redirect && mem_ready && (outst.size() < QDEPTH);
    exp_valid = 1'b0;
    if (outst.size() > 0) exp_valid = (outst[0] + 3 <= cyc);
    if (chk_en) begin
      chk("im_ren", {31'h0, im_ren}, {31'h0, exp_ren});
      chk("im_addr", {18'h0, im_addr}, {18'h0, m_fpc[15:2]});
      chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
      if (exp_valid) begin
        chk("inst_pc", inst_pc, m_head);
        chk("inst", inst, {18'h0, m_head[15:2]});
      end
    end
    if (rst) begin
      outst.delete();
      m_fpc  = {RESET_PC[31:2], 2'b00};
      m_head = {RESET_PC[31:2], 2'b00};
    end else if (redirect) begin
      outst.delete();
      m_fpc  = {redirect_pc[31:2], 2'b00};
      m_head = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_valid && inst_ready) begin
        void'(outst.pop_front());
        m_head = m_head + 32'd4;
      end
      if (exp_ren) begin
        outst.push_back(cyc);
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset: first cycle state is unknown, so only the model advances.
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_im_addr", {18'h0, im_addr}, {18'h0, RESET_PC[15:2]});
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    rst = 1'b0;

    // Streaming from RESET_PC with everything ready.
    run(20);

    // Decode stall then release.
    inst_ready = 1'b0;
    run(10);
    chk("stall_ren", {31'h0, im_ren}, 32'h0);
    inst_ready = 1'b1;
    run(10);

    // Redirect with a partly filled queue and reads in flight.
    inst_ready = 1'b0;
    run(2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    inst_ready = 1'b1;
    run(12);

    // Memory sync window of 4 cycles.
    mem_ready = 1'b0;
    run(4);
    mem_ready = 1'b1;
    run(10);

    // Address wrap across the 14-bit word space.
    redirect = 1'b1;
    redirect_pc = 32'h0000_FFFC;
    tick();
    redirect = 1'b0;
    run(10);

    // Reset while the queue is full.
    inst_ready = 1'b0;
    run(8);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_mid_addr", {18'h0, im_addr}, {18'h0, RESET_PC[15:2]});
    rst = 1'b0;
    inst_ready = 1'b1;
    run(10);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      mem_ready   = ($urandom_range(0, 9) < 8);
      inst_ready  = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 99) < 3);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    redirect = 1'b0;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
